// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multi-cycle RV32I-subset core (ADD SUB AND OR SLT ADDI LUI
// LW SW BEQ BNE JAL). One shared instruction/data memory port with a req/rdy
// handshake; every other opcode, and any misaligned branch/jump target or
// load/store address, parks the core in HALT until reset.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   mem_req / mem_we     request valid / store (1) vs. read (0)
//   mem_addr / mem_wdata word-aligned byte address / store data
//   mem_rdy / mem_rdata  transfer completes on req&&rdy / read data
//   a0                   live contents of x10
//   retire               one-cycle pulse per completed instruction
//   halted               core stopped on an illegal or misaligned condition
module riscv_multicycle #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rdy,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] a0,
    output logic            retire,
    output logic            halted
);
    localparam int RIDX = $clog2(NREGS);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] pc, a_reg, b_reg, imm_reg, alu_out, mdr;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [NREGS];

    // Instruction fields; ir is stable from DECODE through retire.
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [RIDX-1:0] rs1, rs2, rd;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[15 +: RIDX];
    assign rs2    = ir[20 +: RIDX];
    assign rd     = ir[7 +: RIDX];

    logic is_r, is_r_ok, is_addi, is_lui, is_lw, is_sw, is_br, is_jal, legal;

    assign is_r    = (opcode == 7'h33);
    assign is_r_ok = (funct7 == 7'h00 && (funct3 == 3'd0 || funct3 == 3'd2 ||
                                          funct3 == 3'd6 || funct3 == 3'd7)) ||
                     (funct7 == 7'h20 && funct3 == 3'd0);
    assign is_addi = (opcode == 7'h13) && (funct3 == 3'd0);
    assign is_lui  = (opcode == 7'h37);
    assign is_lw   = (opcode == 7'h03) && (funct3 == 3'd2);
    assign is_sw   = (opcode == 7'h23) && (funct3 == 3'd2);
    assign is_br   = (opcode == 7'h63) && (funct3 == 3'd0 || funct3 == 3'd1);
    assign is_jal  = (opcode == 7'h6F);
    assign legal   = (is_r && is_r_ok) || is_addi || is_lui || is_lw || is_sw || is_br || is_jal;

    // Sign-extended immediate for the decoded format.
    logic [XLEN-1:0] imm_dec;
    always_comb begin
        imm_dec = {{(XLEN-11){ir[31]}}, ir[30:20]};                                   // I
        if (is_sw)
            imm_dec = {{(XLEN-11){ir[31]}}, ir[30:25], ir[11:7]};                     // S
        else if (is_br)
            imm_dec = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};        // B
        else if (is_lui)
            imm_dec = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};                        // U
        else if (is_jal)
            imm_dec = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};      // J
    end

    // EXEC datapath: ALU result, branch decision and alignment check.
    logic [XLEN-1:0] alu_res, br_target, pc_plus4;
    logic            br_taken, exec_misalign;

    assign pc_plus4  = pc + XLEN'(4);
    assign br_target = pc + imm_reg;
    assign br_taken  = (a_reg == b_reg) ^ funct3[0];   // funct3[0]=1 is BNE

    always_comb begin
        alu_res = a_reg + imm_reg;                      // ADDI, LW/SW address
        if (is_r) begin
            case (funct3)
                3'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
                3'd6:    alu_res = a_reg | b_reg;
                3'd7:    alu_res = a_reg & b_reg;
                default: alu_res = funct7[5] ? (a_reg - b_reg) : (a_reg + b_reg);
            endcase
        end else if (is_lui) begin
            alu_res = imm_reg;
        end else if (is_jal) begin
            alu_res = pc + imm_reg;
        end
    end

    // Catch bad targets/addresses in EXEC so no request is issued and pc holds.
    assign exec_misalign = (is_br && br_taken && br_target[1:0] != 2'b00) ||
                           ((is_jal || is_lw || is_sw) && alu_res[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_rdy) state_nxt = S_DECODE;
            S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (exec_misalign)        state_nxt = S_HALT;
                else if (is_br)           state_nxt = S_FETCH;
                else if (is_lw || is_sw)  state_nxt = S_MEM;
                else                      state_nxt = S_WB;
            end
            S_MEM:    if (mem_rdy) state_nxt = is_lw ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Outputs; rst gates the strobes so an in-flight request drops at once.
    always_comb begin
        mem_req   = !rst && (state == S_FETCH || state == S_MEM);
        mem_we    = (state == S_MEM) && is_sw;
        mem_addr  = (state == S_MEM) ? alu_out : pc;
        mem_wdata = b_reg;
        retire    = !rst && ((state == S_EXEC && is_br && !exec_misalign) ||
                             (state == S_MEM && is_sw && mem_rdy) ||
                             (state == S_WB));
        halted    = !rst && (state == S_HALT);
    end

    // Datapath registers and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            imm_reg <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_rdy) ir <= mem_rdata[31:0];
                S_DECODE: begin
                    a_reg   <= rf[rs1];
                    b_reg   <= rf[rs2];
                    imm_reg <= imm_dec;
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_br && !exec_misalign) pc <= br_taken ? br_target : pc_plus4;
                end
                S_MEM: begin
                    if (mem_rdy) begin
                        if (is_lw) mdr <= mem_rdata;
                        else       pc  <= pc_plus4;
                    end
                end
                S_WB: begin
                    // rf[0] is never written, so x0 reads as zero forever.
                    if (rd != '0) rf[rd] <= is_lw ? mdr : (is_jal ? pc_plus4 : alu_out);
                    pc <= is_jal ? alu_out : pc_plus4;
                end
                default: ;
            endcase
        end
    end

    assign a0 = rf[10];

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: programs live at 0x100 (RESET_PC),
// data below 0x100. Optional stall mode holds mem_rdy low for the first three
// cycles of every request.
module tb_riscv_multicycle;
    logic        clk, rst;
    logic        mem_req, mem_we, mem_rdy, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, a0;

    riscv_multicycle #(.XLEN(32), .RESET_PC(32'h100), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .a0(a0), .retire(retire), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] prog [32];   // 0x100..0x17C, written by the stimulus only
    logic [31:0] dmem [64];   // 0x000..0x0FC, written by stores only
    logic        stall_en;
    int          wait_cnt, st_cnt, mis_req, unstable;
    logic [31:0] st_addr, st_data, p_addr, p_wdata;
    logic        p_pend, p_we;
    int          tests, fails;

    assign mem_rdata = mem_addr[8] ? prog[mem_addr[6:2]] : dmem[mem_addr[7:2]];
    assign mem_rdy   = stall_en ? (wait_cnt >= 3) : 1'b1;

    initial begin
        wait_cnt = 0; st_cnt = 0; mis_req = 0; unstable = 0;
        p_pend = 1'b0; p_addr = '0; p_we = 1'b0; p_wdata = '0;
        st_addr = '0; st_data = '0;
    end

    // Memory side: stores, wait-state counter, handshake stability monitor.
    always @(posedge clk) begin
        if (mem_req && mem_rdy && mem_we) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
            st_cnt  <= st_cnt + 1;
        end
        if (mem_req && mem_addr[1:0] != 2'b00) mis_req <= mis_req + 1;
        if (p_pend && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
            unstable <= unstable + 1;
        p_pend   <= mem_req && !mem_rdy;
        p_addr   <= mem_addr;
        p_we     <= mem_we;
        p_wdata  <= mem_wdata;
        wait_cnt <= (!mem_req || mem_rdy) ? 0 : wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge of an instruction's first cycle. Returns the
    // 1-based cycle in which retire (or halted) is seen, 0 on timeout, and
    // leaves the bench on the negedge of the following instruction's first cycle.
    task automatic run_instr(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            if (retire || halted) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        if (retire) @(negedge clk);
    endtask

    // Holds rst over one edge, checks the gated outputs, then releases.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst_req"},    {31'b0, mem_req}, 32'd0);
        check({tag, "_rst_retire"}, {31'b0, retire},  32'd0);
        check({tag, "_rst_halted"}, {31'b0, halted},  32'd0);
        rst = 1'b0;
        #1;
        check({tag, "_fetch_req"},  {31'b0, mem_req}, 32'd1);
        check({tag, "_fetch_addr"}, mem_addr,         32'h100);
        check({tag, "_a0_clear"},   a0,               32'd0);
    endtask

    int cyc;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; stall_en = 1'b0;
        for (int i = 0; i < 32; i++) prog[i] = 32'h0000007F;
        prog[0]  = 32'h00500513;  // addi x10,x0,5
        prog[1]  = 32'h00A02423;  // sw   x10,8(x0)
        prog[2]  = 32'h00802583;  // lw   x11,8(x0)
        prog[3]  = 32'h00B58533;  // add  x10,x11,x11
        prog[4]  = 32'h40A58533;  // sub  x10,x11,x10
        prog[5]  = 32'h00B52533;  // slt  x10,x10,x11
        prog[6]  = 32'h12345537;  // lui  x10,0x12345
        prog[7]  = 32'h00B56533;  // or   x10,x10,x11
        prog[8]  = 32'h00B57533;  // and  x10,x10,x11
        prog[9]  = 32'h00700013;  // addi x0,x0,7
        prog[10] = 32'h00000533;  // add  x10,x0,x0
        prog[11] = 32'h00001463;  // 0x12C bne x0,x0,+8
        prog[12] = 32'h00C000EF;  // 0x130 jal x1,+12
        prog[15] = 32'h00008533;  // 0x13C add x10,x1,x0
        prog[16] = 32'h0080006F;  // 0x140 jal x0,+8
        prog[17] = 32'h00C0006F;  // 0x144 jal x0,+12
        prog[18] = 32'hFE000EE3;  // 0x148 beq x0,x0,-4
        prog[20] = 32'h00602503;  // 0x150 lw x10,6(x0)
        @(negedge clk);
        do_reset("r1");

        run_instr(cyc); check("addi_cyc", 32'(cyc), 32'd4); check("addi_a0", a0, 32'd5);
        run_instr(cyc); check("sw_cyc", 32'(cyc), 32'd4);
        check("sw_cnt", 32'(st_cnt), 32'd1); check("sw_addr", st_addr, 32'd8); check("sw_data", st_data, 32'd5);
        run_instr(cyc); check("lw_cyc", 32'(cyc), 32'd5);
        run_instr(cyc); check("add_cyc", 32'(cyc), 32'd4); check("add_a0", a0, 32'd10);
        run_instr(cyc); check("sub_a0", a0, 32'hFFFFFFFB);
        run_instr(cyc); check("slt_a0", a0, 32'd1);
        run_instr(cyc); check("lui_cyc", 32'(cyc), 32'd4); check("lui_a0", a0, 32'h12345000);
        run_instr(cyc); check("or_a0", a0, 32'h12345005);
        run_instr(cyc); check("and_a0", a0, 32'd5);
        run_instr(cyc); check("addi_x0_cyc", 32'(cyc), 32'd4);
        run_instr(cyc); check("x0_zero_a0", a0, 32'd0);
        run_instr(cyc); check("bne_cyc", 32'(cyc), 32'd3); check("bne_pc", mem_addr, 32'h130);
        run_instr(cyc); check("jal_cyc", 32'(cyc), 32'd4); check("jal_pc", mem_addr, 32'h13C);
        run_instr(cyc); check("jal_link_a0", a0, 32'h134);
        run_instr(cyc); check("jal8_pc", mem_addr, 32'h148);
        run_instr(cyc); check("beq_cyc", 32'(cyc), 32'd3); check("beq_pc", mem_addr, 32'h144);
        run_instr(cyc); check("jal12_pc", mem_addr, 32'h150);
        run_instr(cyc); check("lw_mis_cyc", 32'(cyc), 32'd4); check("lw_mis_halt", {31'b0, halted}, 32'd1);
        repeat (3) @(negedge clk);
        check("lw_mis_req", {31'b0, mem_req}, 32'd0);
        check("lw_mis_still", {31'b0, halted}, 32'd1);
        check("mis_req_cnt", 32'(mis_req), 32'd0);
        check("lw_mis_a0", a0, 32'h134);

        // Illegal opcode right at RESET_PC; reset also clears the halt.
        prog[0] = 32'h0000007F;
        do_reset("r2");
        check("r2_unhalted", {31'b0, halted}, 32'd0);
        run_instr(cyc); check("ill_cyc", 32'(cyc), 32'd3); check("ill_halt", {31'b0, halted}, 32'd1);
        repeat (2) @(negedge clk);
        check("ill_req", {31'b0, mem_req}, 32'd0);

        // Three wait states on every transfer.
        prog[0] = 32'h00500513;  // addi x10,x0,5
        prog[1] = 32'h00A02623;  // sw   x10,12(x0)
        prog[2] = 32'h00C02583;  // lw   x11,12(x0)
        prog[3] = 32'h00B58533;  // add  x10,x11,x11
        stall_en = 1'b1;
        do_reset("r3");
        run_instr(cyc); check("st_addi_cyc", 32'(cyc), 32'd7); check("st_addi_a0", a0, 32'd5);
        run_instr(cyc); check("st_sw_cyc", 32'(cyc), 32'd10);
        check("st_sw_cnt", 32'(st_cnt), 32'd2); check("st_sw_addr", st_addr, 32'd12); check("st_sw_data", st_data, 32'd5);
        run_instr(cyc); check("st_lw_cyc", 32'(cyc), 32'd11);
        run_instr(cyc); check("st_add_cyc", 32'(cyc), 32'd7); check("st_add_a0", a0, 32'd10);
        check("stable", 32'(unstable), 32'd0);

        // Reset while a stalled fetch is outstanding.
        @(negedge clk);
        check("mid_req_pending", {31'b0, mem_req}, 32'd1);
        do_reset("r4");
        check("r4_wait_clr", 32'(wait_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
